// File: rtl/alu_md_if.sv
// Request/response bundle for alu_md: handshake, operands, result and the HI/LO view.
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       sel;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, sel, op1, op2,
        input  in_ready, out_valid, result, zero, hi, lo
    );
    modport slave (
        input  in_valid, sel, op1, op2,
        output in_ready, out_valid, result, zero, hi, lo
    );
endinterface

// File: rtl/alu_md.sv
// MIPS-style ALU with HI/LO multiply/divide unit: single-cycle ALU ops,
// iterative (one bit per cycle) shift-add multiply and restoring divide.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     reset,
    alu_md_if.slave io
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;

    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   alu_r;
    logic [WIDTH:0]     madd, dtrial;
    logic [2*WIDTH-1:0] step, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               sgn;

    assign sh = io.op1[SHW-1:0];

    always_comb begin
        alu_r = '0;
        case (io.sel[3:0])
            4'd0:  alu_r = WIDTH'(!io.op1[WIDTH-1]);
            4'd1:  alu_r = WIDTH'(io.op1[WIDTH-1]);
            4'd2:  alu_r = io.op1 + io.op2;
            4'd3:  alu_r = io.op1 - io.op2;
            4'd4:  alu_r = io.op1 & io.op2;
            4'd5:  alu_r = io.op1 | io.op2;
            4'd6:  alu_r = io.op1 ^ io.op2;
            4'd7:  alu_r = ~(io.op1 | io.op2);
            4'd8:  alu_r = io.op2 >> sh;
            4'd9:  alu_r = $unsigned($signed(io.op2) >>> sh);
            4'd10: alu_r = io.op2 << sh;
            4'd11: alu_r = WIDTH'(io.op1 == io.op2);
            4'd12: alu_r = WIDTH'($signed(io.op1) < $signed(io.op2));
            4'd13: alu_r = WIDTH'(io.op1 < io.op2);
            4'd14: alu_r = WIDTH'(!io.op1[WIDTH-1] && (|io.op1));
            4'd15: alu_r = WIDTH'(io.op1[WIDTH-1] || !(|io.op1));
        endcase
    end

    // acc holds {partial, multiplier} for mult and {remainder, dividend} for div;
    // both units work on magnitudes and fix signs on the last iteration.
    always_comb begin
        madd   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        dtrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
        if (is_div_q)
            step = dtrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            step = {madd, acc_q[WIDTH-1:1]};
        prod = neg_q ? -step : step;
        quo  = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        b_d         = b_q;
        a_d         = a_q;
        is_div_d    = is_div_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        sgn         = ~io.sel[0];

        if (state_q == IDLE) begin
            if (io.in_valid) begin
                if (io.sel[4:2] == 3'b100) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    is_div_d = io.sel[1];
                    a_d      = io.op1;
                    acc_d    = {{WIDTH{1'b0}}, (sgn && io.op1[WIDTH-1]) ? -io.op1 : io.op1};
                    b_d      = (sgn && io.op2[WIDTH-1]) ? -io.op2 : io.op2;
                    neg_d    = sgn && (io.op1[WIDTH-1] ^ io.op2[WIDTH-1]);
                    rneg_d   = sgn && io.op1[WIDTH-1];
                end else begin
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    if (!io.sel[4])
                        result_d = alu_r;
                    else if (io.sel[4:2] == 3'b101) begin
                        case (io.sel[1:0])
                            2'd0: result_d = hi_q;
                            2'd1: result_d = lo_q;
                            2'd2: hi_d = io.op1;
                            2'd3: lo_d = io.op1;
                        endcase
                    end
                end
            end
        end else begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == (SHW+1)'(WIDTH-1)) begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                result_d = lo_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            a_q         <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            a_q         <= a_d;
            is_div_q    <= is_div_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.zero      = (result_q == '0);
    assign io.hi        = hi_q;
    assign io.lo        = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md (WIDTH=32): vector table for single-cycle ops,
// hand-written sequences for multiply/divide, HI/LO moves and reset abort.
module tb_alu_md;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(W)) io();
    alu_md #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .io(io));

    typedef struct {
        logic [4:0]   sel;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic issue(input logic [4:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        io.in_valid = 1'b1;
        io.sel      = s;
        io.op1      = a;
        io.op2      = b;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    // Issues a mult/div, checks the busy window and the completion cycle.
    task automatic run_md(input string name, input logic [4:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input bit junk);
        bit bad;
        bad = 1'b0;
        issue(s, a, b);
        chk({name, " busy"}, {io.in_ready, io.out_valid}, 2'b00);
        for (int i = 1; i < W; i++) begin
            if (junk) begin
                io.in_valid = 1'b1;
                io.sel      = 5'd2;
                io.op1      = $urandom;
                io.op2      = $urandom;
            end
            @(posedge clk);
            #1;
            if (io.in_ready || io.out_valid) bad = 1'b1;
        end
        io.in_valid = 1'b0;
        chk({name, " window"}, bad, 1'b0);
        @(posedge clk);
        #1;
        chk({name, " done"}, {io.out_valid, io.in_ready}, 2'b11);
        chk({name, " hi"}, io.hi, ehi);
        chk({name, " lo"}, io.lo, elo);
        chk({name, " result"}, io.result, elo);
        if (junk) begin
            @(posedge clk);
            #1;
            chk({name, " single pulse"}, io.out_valid, 1'b0);
        end
    endtask

    initial begin
        bit seen;
        io.in_valid = 1'b0;
        io.sel      = '0;
        io.op1      = '0;
        io.op2      = '0;

        vecs[0]  = '{5'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{5'd3,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[2]  = '{5'd0,  32'h80000000, 32'h00000000, 32'h00000000};
        vecs[3]  = '{5'd0,  32'h00000000, 32'h00000000, 32'h00000001};
        vecs[4]  = '{5'd1,  32'h80000000, 32'h00000000, 32'h00000001};
        vecs[5]  = '{5'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vecs[6]  = '{5'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
        vecs[7]  = '{5'd6,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00};
        vecs[8]  = '{5'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[9]  = '{5'd8,  32'h00000024, 32'h80000000, 32'h08000000};
        vecs[10] = '{5'd9,  32'h00000004, 32'h80000000, 32'hF8000000};
        vecs[11] = '{5'd10, 32'h0000001F, 32'h00000003, 32'h80000000};
        vecs[12] = '{5'd11, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001};
        vecs[13] = '{5'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[14] = '{5'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[15] = '{5'd14, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[16] = '{5'd15, 32'h00000000, 32'h00000000, 32'h00000001};
        vecs[17] = '{5'd22, 32'hA5A5A5A5, 32'h00000000, 32'h00000000};
        vecs[18] = '{5'd20, 32'h00000000, 32'h00000000, 32'hA5A5A5A5};
        vecs[19] = '{5'd23, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[20] = '{5'd21, 32'h00000000, 32'h00000000, 32'h12345678};
        vecs[21] = '{5'd26, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

        #12;
        chk("reset outputs", {io.in_ready, io.out_valid, io.zero, io.result, io.hi, io.lo},
            {3'b101, 96'h0});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            issue(vecs[i].sel, vecs[i].op1, vecs[i].op2);
            chk($sformatf("vec%0d sel%0d result", i, vecs[i].sel), io.result, vecs[i].exp);
            chk($sformatf("vec%0d valid/ready/zero", i), {io.out_valid, io.in_ready, io.zero},
                {2'b11, vecs[i].exp == 0});
        end
        chk("hilo kept after sel26", {io.hi, io.lo}, {32'hA5A5A5A5, 32'h12345678});
        @(posedge clk);
        #1;
        chk("valid drops", io.out_valid, 1'b0);

        run_md("mult", 5'd16, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
        run_md("multu", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_md("div neg", 5'd18, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_md("div ovf", 5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_md("div posneg", 5'd18, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
        run_md("divu", 5'd19, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_md("divu by0", 5'd19, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b0);
        issue(5'd20, 32'h0, 32'h0);
        chk("mfhi after divu", {io.out_valid, io.result}, {1'b1, 32'h1234});
        run_md("div by0", 5'd18, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
        issue(5'd21, 32'h0, 32'h0);
        chk("mflo after div", io.result, 32'hFFFFFFFF);

        // Abort a multiply mid-flight with reset.
        issue(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort hi/lo", {io.hi, io.lo}, 64'h0);
        chk("abort flags", {io.in_ready, io.out_valid, io.zero, io.result}, {3'b101, 32'h0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset       = 1'b1;
        io.in_valid = 1'b1;
        io.sel      = 5'd3;
        io.op1      = 32'd10;
        io.op2      = 32'd3;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        chk("first edge accept", {io.out_valid, io.result}, {1'b1, 32'd7});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid) seen = 1'b1;
        end
        chk("no pulse after abort", seen, 1'b0);
        chk("hi/lo after abort", {io.hi, io.lo, io.in_ready}, {64'h0, 1'b1});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
